// File: rtl/cachegen.sv
// cachegen: cache request generator for dcache simulation experiments.
// After reset it waits HOLDOFF cycles, then issues NUM_REQ requests per pass
// at BASE_ADDR + index*STRIDE with DISTANCE idle cycles between them.
// MODE=1 runs a write pass then a read-back pass; LOOP selects repeat or stop.
// Optional feature macro: CACHEGEN_CHECK_EN (hardware check of read-back data).
module cachegen #(
    parameter int unsigned ADDR_WIDTH = 32'd24,
    parameter int unsigned DATA_WIDTH = 32'd32,
    parameter int unsigned HOLDOFF    = 32'd80,
    parameter int unsigned DISTANCE   = 32'd6,
    parameter int unsigned NUM_REQ    = 32'd3,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0] STRIDE    = ADDR_WIDTH'(32'd4),
    parameter int unsigned MODE       = 32'd0,
    parameter int unsigned LOOP       = 32'd1,
    parameter logic [DATA_WIDTH-1:0] DATA_SEED = DATA_WIDTH'(32'h5A5A0000)
) (
    input  logic                  clk,
    input  logic                  rst,
    output logic                  valid_out,
    output logic                  wr_out,
    output logic [ADDR_WIDTH-1:0] addr_out,
    output logic [DATA_WIDTH-1:0] data_out,
    input  logic                  ready_in,
    input  logic [DATA_WIDTH-1:0] data_in,
    output logic                  done_out,
    output logic                  err_out,
    output logic [7:0]            err_cnt_out
);

    localparam int unsigned IDX_W = (NUM_REQ > 32'd1) ? $clog2(NUM_REQ) : 32'd1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 32'd1);
    localparam int unsigned CW = (ADDR_WIDTH < DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam bit MODE_WR   = (MODE == 32'd1);
    localparam bit LOOP_EN   = (LOOP != 32'd0);
    localparam bit DIST_ZERO = (DISTANCE == 32'd0);

    typedef enum logic [1:0] {
        S_HOLD  = 2'd0,
        S_ISSUE = 2'd1,
        S_GAP   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    // Write pattern: zero-extended address XOR the seed.
    function automatic logic [DATA_WIDTH-1:0] f_pattern(input logic [ADDR_WIDTH-1:0] addr);
        logic [DATA_WIDTH-1:0] v;
        v = '0;
        v[CW-1:0] = addr[CW-1:0];
        return v ^ DATA_SEED;
    endfunction

    state_t                r_state;
    logic [15:0]           r_hold;
    logic [7:0]            r_gap;
    logic [IDX_W-1:0]      r_idx;
    logic                  r_pass;
    logic                  r_valid;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_done;

    logic                  w_last_idx;
    logic                  w_seq_end;
    logic [IDX_W-1:0]      w_next_idx;
    logic                  w_next_pass;
    logic [ADDR_WIDTH-1:0] w_next_addr;
    logic                  w_next_wr;
    logic [DATA_WIDTH-1:0] w_next_data;
    logic                  w_cur_wr;
    logic [DATA_WIDTH-1:0] w_cur_data;

    // The request that follows the one currently presented.
    assign w_last_idx  = (r_idx == LAST_IDX);
    assign w_seq_end   = w_last_idx & (~MODE_WR | r_pass);
    assign w_next_idx  = w_last_idx ? '0 : r_idx + IDX_W'(1'b1);
    assign w_next_pass = MODE_WR ? (r_pass ^ w_last_idx) : 1'b0;
    assign w_next_addr = w_last_idx ? BASE_ADDR : r_addr + STRIDE;
    assign w_next_wr   = MODE_WR & ~w_next_pass;
    assign w_next_data = w_next_wr ? f_pattern(w_next_addr) : '0;

    // The request held in index/pass/addr, used when leaving HOLD or GAP.
    assign w_cur_wr    = MODE_WR & ~r_pass;
    assign w_cur_data  = w_cur_wr ? f_pattern(r_addr) : '0;

    // Sequencer: hold-off, issue with handshake, inter-request gap, done.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= S_HOLD;
            r_hold  <= 16'(HOLDOFF);
            r_gap   <= 8'd0;
            r_idx   <= '0;
            r_pass  <= 1'b0;
            r_valid <= 1'b0;
            r_wr    <= 1'b0;
            r_addr  <= BASE_ADDR;
            r_data  <= '0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                S_HOLD: begin
                    if (r_hold == 16'd0) begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                        r_wr    <= w_cur_wr;
                        r_data  <= w_cur_data;
                    end else begin
                        r_hold  <= r_hold - 16'd1;
                    end
                end
                S_ISSUE: begin
                    if (ready_in) begin
                        r_idx  <= w_next_idx;
                        r_pass <= w_next_pass;
                        r_addr <= w_next_addr;
                        if (w_seq_end && !LOOP_EN) begin
                            r_state <= S_DONE;
                            r_valid <= 1'b0;
                            r_done  <= 1'b1;
                            r_wr    <= 1'b0;
                            r_data  <= '0;
                        end else if (DIST_ZERO) begin
                            r_state <= S_ISSUE;
                            r_valid <= 1'b1;
                            r_wr    <= w_next_wr;
                            r_data  <= w_next_data;
                        end else begin
                            r_state <= S_GAP;
                            r_gap   <= 8'(DISTANCE);
                            r_valid <= 1'b0;
                            r_wr    <= w_next_wr;
                            r_data  <= w_next_data;
                        end
                    end else begin
                        r_state <= S_ISSUE;
                    end
                end
                S_GAP: begin
                    r_gap <= r_gap - 8'd1;
                    if (r_gap <= 8'd1) begin
                        r_state <= S_ISSUE;
                        r_valid <= 1'b1;
                        r_wr    <= w_cur_wr;
                        r_data  <= w_cur_data;
                    end else begin
                        r_state <= S_GAP;
                    end
                end
                S_DONE: begin
                    r_valid <= 1'b0;
                    r_done  <= 1'b1;
                end
                default: begin
                    r_state <= S_HOLD;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign valid_out = r_valid;
    assign wr_out    = r_wr;
    assign addr_out  = r_addr;
    assign data_out  = r_data;
    assign done_out  = r_done;

`ifdef CACHEGEN_CHECK_EN
    logic       r_err;
    logic [7:0] r_err_cnt;

    // Read-back checker: sticky error flag plus saturating mismatch count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_err     <= 1'b0;
            r_err_cnt <= 8'd0;
        end else if (MODE_WR && r_state == S_ISSUE && r_valid && ready_in && !r_wr) begin
            if (data_in != f_pattern(r_addr)) begin
                r_err <= 1'b1;
                if (r_err_cnt != 8'hFF) begin
                    r_err_cnt <= r_err_cnt + 8'd1;
                end else begin
                    r_err_cnt <= r_err_cnt;
                end
            end else begin
                r_err <= r_err;
            end
        end else begin
            r_err <= r_err;
        end
    end

    assign err_out     = r_err;
    assign err_cnt_out = r_err_cnt;
`else
    logic w_unused_data;

    assign w_unused_data = ^data_in;
    assign err_out       = 1'b0;
    assign err_cnt_out   = 8'd0;
`endif

endmodule

// File: tb/tb_cachegen.sv
// tb_cachegen: four cachegen instances with different configurations, all
// compared every cycle against a request-count/countdown model of the
// generator, plus literal expectations pinning key sequences.
module tb_cachegen;

    localparam int NI = 4;
    localparam int     C_AW    [NI] = '{32'd24, 32'd24, 32'd24, 32'd8};
    localparam int     C_DW    [NI] = '{32'd32, 32'd32, 32'd32, 32'd16};
    localparam int     C_HOLD  [NI] = '{32'd80, 32'd3,  32'd5,  32'd0};
    localparam int     C_DIST  [NI] = '{32'd6,  32'd0,  32'd2,  32'd1};
    localparam int     C_NUM   [NI] = '{32'd3,  32'd4,  32'd2,  32'd5};
    localparam longint C_BASE  [NI] = '{64'h0, 64'h10, 64'h100, 64'hF0};
    localparam longint C_STRIDE[NI] = '{64'h4, 64'h100, 64'h4, 64'h8};
    localparam int     C_MODE  [NI] = '{32'd0,  32'd1,  32'd1,  32'd1};
    localparam int     C_LOOP  [NI] = '{32'd1,  32'd1,  32'd0,  32'd1};
    localparam longint C_SEED  [NI] = '{64'h5A5A0000, 64'h12345678, 64'h5A5A0000, 64'hA5C3};
`ifdef CACHEGEN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic [NI-1:0] t_rdy = '0;
    logic [31:0]   t_din [NI];

    logic [NI-1:0] o_valid, o_wr, o_done, o_err;
    logic [31:0]   o_addr [NI];
    logic [31:0]   o_data [NI];
    logic [7:0]    o_cnt  [NI];
    logic [23:0]   a0, a1, a2;
    logic [7:0]    a3;
    logic [15:0]   d3;

    always #5 clk = ~clk;

    cachegen u0 (.clk(clk), .rst(rst), .valid_out(o_valid[0]), .wr_out(o_wr[0]),
        .addr_out(a0), .data_out(o_data[0]), .ready_in(t_rdy[0]), .data_in(t_din[0]),
        .done_out(o_done[0]), .err_out(o_err[0]), .err_cnt_out(o_cnt[0]));

    cachegen #(.HOLDOFF(3), .DISTANCE(0), .NUM_REQ(4), .BASE_ADDR(24'h000010),
        .STRIDE(24'h000100), .MODE(1), .LOOP(1), .DATA_SEED(32'h12345678)) u1 (
        .clk(clk), .rst(rst), .valid_out(o_valid[1]), .wr_out(o_wr[1]),
        .addr_out(a1), .data_out(o_data[1]), .ready_in(t_rdy[1]), .data_in(t_din[1]),
        .done_out(o_done[1]), .err_out(o_err[1]), .err_cnt_out(o_cnt[1]));

    cachegen #(.HOLDOFF(5), .DISTANCE(2), .NUM_REQ(2), .BASE_ADDR(24'h000100),
        .STRIDE(24'h000004), .MODE(1), .LOOP(0)) u2 (
        .clk(clk), .rst(rst), .valid_out(o_valid[2]), .wr_out(o_wr[2]),
        .addr_out(a2), .data_out(o_data[2]), .ready_in(t_rdy[2]), .data_in(t_din[2]),
        .done_out(o_done[2]), .err_out(o_err[2]), .err_cnt_out(o_cnt[2]));

    cachegen #(.ADDR_WIDTH(8), .DATA_WIDTH(16), .HOLDOFF(0), .DISTANCE(1), .NUM_REQ(5),
        .BASE_ADDR(8'hF0), .STRIDE(8'h08), .MODE(1), .LOOP(1), .DATA_SEED(16'hA5C3)) u3 (
        .clk(clk), .rst(rst), .valid_out(o_valid[3]), .wr_out(o_wr[3]),
        .addr_out(a3), .data_out(d3), .ready_in(t_rdy[3]), .data_in(t_din[3][15:0]),
        .done_out(o_done[3]), .err_out(o_err[3]), .err_cnt_out(o_cnt[3]));

    assign o_addr[0] = {8'd0, a0};
    assign o_addr[1] = {8'd0, a1};
    assign o_addr[2] = {8'd0, a2};
    assign o_addr[3] = {24'd0, a3};
    assign o_data[3] = {16'd0, d3};

    // model: completed-request count, cycles until valid, done/error state
    int m_n [NI];
    int m_wait [NI];
    bit m_done [NI];
    bit m_err [NI];
    int m_cnt [NI];

    int n_tests = 0;
    int n_fail = 0;
    int ecyc = 0;
    int epoch = 0;
    bit u2_corrupted = 1'b0;
    bit prev0 = 1'b0;
    bit u1_seen = 1'b0;
    int u1_gaps = 0;
    int rises0[$];
    longint q0_addr[$], q1_addr[$], q3_addr[$];
    longint q2_wr[$], q2_addr[$], q2_data[$];

    function automatic longint amask(int i);
        return (64'd1 << C_AW[i]) - 64'd1;
    endfunction

    function automatic longint dmask(int i);
        return (64'd1 << C_DW[i]) - 64'd1;
    endfunction

    function automatic longint e_addr(int i);
        return (C_BASE[i] + longint'(m_n[i] % C_NUM[i]) * C_STRIDE[i]) & amask(i);
    endfunction

    function automatic bit e_wr(int i);
        return (C_MODE[i] == 1) && (((m_n[i] / C_NUM[i]) % 2) == 0);
    endfunction

    function automatic longint e_pattern(int i);
        return (e_addr(i) ^ C_SEED[i]) & dmask(i);
    endfunction

    function automatic longint e_data(int i);
        return e_wr(i) ? e_pattern(i) : 64'd0;
    endfunction

    function automatic bit e_valid(int i);
        return !m_done[i] && (m_wait[i] == 0);
    endfunction

    task automatic chk(input string name, input int inst, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s u%0d ep%0d cyc%0d: got %0h expected %0h", name, inst, epoch, ecyc, act, exp);
        end
    endtask

    task automatic check_all();
        for (int i = 0; i < NI; i++) begin
            chk("valid", i, longint'(o_valid[i]), longint'(e_valid(i)));
            chk("done", i, longint'(o_done[i]), longint'(m_done[i]));
            chk("err", i, longint'(o_err[i]), longint'(m_err[i]));
            chk("err_cnt", i, longint'(o_cnt[i]), longint'(m_cnt[i]));
            if (e_valid(i)) begin
                chk("wr", i, longint'(o_wr[i]), longint'(e_wr(i)));
                chk("addr", i, longint'(o_addr[i]), e_addr(i));
                chk("data", i, longint'(o_data[i]), e_data(i));
            end
        end
        if (o_valid[0] && !prev0) rises0.push_back(ecyc);
        prev0 = o_valid[0];
        if (u1_seen && !o_valid[1]) u1_gaps++;
        if (o_valid[1]) u1_seen = 1'b1;
    endtask

    // choose inputs for the coming edge and advance the model across it
    task automatic step(input bit force_rdy);
        for (int i = 0; i < NI; i++) begin
            bit rdy;
            bit fin;
            longint din;
            rdy = (force_rdy && i < 2) ? 1'b1 : ($urandom_range(0, 99) < 65);
            din = longint'($urandom) & dmask(i);
            if (e_valid(i) && !e_wr(i) && C_MODE[i] == 1) begin
                din = e_pattern(i);
                if (i == 2 && epoch == 1 && !u2_corrupted) begin
                    din = din ^ 64'h1;
                    u2_corrupted = 1'b1;
                    rdy = 1'b1;
                end else if (i == 3 && $urandom_range(0, 7) == 0) begin
                    din = din ^ (64'h1 << $urandom_range(0, 15));
                end
            end
            t_rdy[i] = rdy;
            t_din[i] = 32'(din);
            if (e_valid(i) && rdy) begin
                if (i == 0) q0_addr.push_back(longint'(o_addr[0]));
                if (i == 1) q1_addr.push_back(longint'(o_addr[1]));
                if (i == 3) q3_addr.push_back(longint'(o_addr[3]));
                if (i == 2) begin
                    q2_wr.push_back(longint'(o_wr[2]));
                    q2_addr.push_back(longint'(o_addr[2]));
                    q2_data.push_back(longint'(o_data[2]));
                end
                if (CHK_EN && C_MODE[i] == 1 && !e_wr(i) && din != e_pattern(i)) begin
                    m_err[i] = 1'b1;
                    if (m_cnt[i] < 255) m_cnt[i]++;
                end
                fin = (((m_n[i] + 1) % C_NUM[i]) == 0) &&
                      (C_MODE[i] == 0 || ((m_n[i] / C_NUM[i]) % 2) == 1);
                m_n[i]++;
                if (fin && C_LOOP[i] == 0) m_done[i] = 1'b1;
                else m_wait[i] = C_DIST[i];
            end else if (!m_done[i] && m_wait[i] > 0) begin
                m_wait[i]--;
            end
        end
    endtask

    task automatic run(input int ncyc, input bit force_rdy);
        for (int k = 0; k < ncyc; k++) begin
            check_all();
            step(force_rdy);
            @(negedge clk);
            ecyc++;
        end
    endtask

    // assert reset (called at a negedge), check async clear, release it
    task automatic do_reset();
        rst = 1'b0;
        #1;
        for (int i = 0; i < NI; i++) begin
            chk("rst_valid", i, longint'(o_valid[i]), 64'd0);
            chk("rst_wr", i, longint'(o_wr[i]), 64'd0);
            chk("rst_addr", i, longint'(o_addr[i]), C_BASE[i]);
            chk("rst_data", i, longint'(o_data[i]), 64'd0);
            chk("rst_done", i, longint'(o_done[i]), 64'd0);
            chk("rst_err", i, longint'(o_err[i]), 64'd0);
            chk("rst_cnt", i, longint'(o_cnt[i]), 64'd0);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        epoch++;
        ecyc = 0;
        for (int i = 0; i < NI; i++) begin
            m_n[i] = 0;
            m_wait[i] = C_HOLD[i] + 1;
            m_done[i] = 1'b0;
            m_err[i] = 1'b0;
            m_cnt[i] = 0;
        end
        prev0 = 1'b0;
        u1_seen = 1'b0;
        u1_gaps = 0;
        rises0.delete();
        q0_addr.delete(); q1_addr.delete(); q3_addr.delete();
        q2_wr.delete(); q2_addr.delete(); q2_data.delete();
    endtask

    // literal expectations for the first part of an epoch
    task automatic pin_epoch();
        longint ew [4] = '{64'd1, 64'd1, 64'd0, 64'd0};
        longint ea [4] = '{64'h100, 64'h104, 64'h100, 64'h104};
        longint ed [4] = '{64'h5A5A0100, 64'h5A5A0104, 64'h0, 64'h0};
        longint a0e [4] = '{64'h0, 64'h4, 64'h8, 64'h0};
        chk("u0_rises", 0, rises0.size() >= 2, 64'd1);
        if (rises0.size() >= 2) begin
            chk("u0_first_valid_cycle", 0, rises0[0], 64'd81);
            chk("u0_rise_spacing", 0, rises0[1] - rises0[0], 64'd7);
        end
        chk("u0_ncomp", 0, q0_addr.size() >= 4, 64'd1);
        if (q0_addr.size() >= 4)
            for (int j = 0; j < 4; j++) chk("u0_addr_seq", 0, q0_addr[j], a0e[j]);
        chk("u1_back_to_back_gaps", 1, u1_gaps, 64'd0);
        chk("u1_ncomp", 1, q1_addr.size() >= 2, 64'd1);
        if (q1_addr.size() >= 2) begin
            chk("u1_addr0", 1, q1_addr[0], 64'h10);
            chk("u1_addr1", 1, q1_addr[1], 64'h110);
        end
        chk("u2_ncomp", 2, q2_addr.size(), 64'd4);
        if (q2_addr.size() >= 4)
            for (int j = 0; j < 4; j++) begin
                chk("u2_seq_wr", 2, q2_wr[j], ew[j]);
                chk("u2_seq_addr", 2, q2_addr[j], ea[j]);
                chk("u2_seq_data", 2, q2_data[j], ed[j]);
            end
        chk("u2_done_out", 2, longint'(o_done[2]), 64'd1);
        chk("u2_valid_after_done", 2, longint'(o_valid[2]), 64'd0);
        chk("u2_err_cnt", 2, longint'(o_cnt[2]), (CHK_EN && epoch == 1) ? 64'd1 : 64'd0);
        chk("u2_err", 2, longint'(o_err[2]), (CHK_EN && epoch == 1) ? 64'd1 : 64'd0);
        chk("u3_ncomp", 3, q3_addr.size() >= 3, 64'd1);
        if (q3_addr.size() >= 3) begin
            chk("u3_addr0", 3, q3_addr[0], 64'hF0);
            chk("u3_addr1", 3, q3_addr[1], 64'hF8);
            chk("u3_addr_wrap", 3, q3_addr[2], 64'h00);
        end
    endtask

    initial begin
        bit found;
        for (int i = 0; i < NI; i++) t_din[i] = 32'd0;
        @(negedge clk);
        do_reset();
        run(200, 1'b1);
        pin_epoch();
        run(1500, 1'b0);
        found = 1'b0;
        for (int k = 0; k < 300 && !found; k++) begin
            check_all();
            if (o_valid[0]) begin
                found = 1'b1;
            end else begin
                step(1'b0);
                @(negedge clk);
                ecyc++;
            end
        end
        chk("midrst_valid_seen", 0, longint'(found), 64'd1);
        do_reset();
        run(200, 1'b1);
        pin_epoch();
        run(300, 1'b0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cachegen.md
Name: cachegen

Overview:
- Parametrised cache request generator for dcache simulation experiments; drives the cache's CPU-side valid/ready port in place of a processor.
- Waits a hold-off period after reset, then issues a programmable address sequence with a programmable idle gap between requests.
- Supports read-only or write-then-read-back modes, one-shot or looping.
- Optional hardware check of read-back data.

Parameters:
- ADDR_WIDTH, 24, width of addr_out.
- DATA_WIDTH, 32, width of data_out/data_in.
- HOLDOFF, 80, idle cycles after reset release before the first request (0..65535).
- DISTANCE, 6, idle cycles between completion of one request and the next valid_out (0..255; 0 = back-to-back).
- NUM_REQ, 3, requests per pass (>=1).
- BASE_ADDR, 0, address of request 0.
- STRIDE, 4, address increment per request; modulo 2^ADDR_WIDTH.
- MODE, 0, 0 = read passes only; 1 = write pass followed by read pass.
- LOOP, 1, 1 = restart the sequence after the last pass; 0 = stop in DONE.
- DATA_SEED, 32'h5A5A0000, XOR pattern for write data.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-low
- valid_out  out  1  request valid
- wr_out  out  1  1 = write, 0 = read
- addr_out  out  ADDR_WIDTH  request address
- data_out  out  DATA_WIDTH  write data
- ready_in  in  1  cache completes request this cycle
- data_in  in  DATA_WIDTH  read data, valid when valid_out & ready_in & ~wr_out
- done_out  out  1  sequence finished (LOOP=0 only)
- err_out  out  1  sticky read-back mismatch
- err_cnt_out  out  8  saturating mismatch count

Behaviour:
- One clock, clk. Reset is asynchronous and active-low on rst; all state and outputs clear immediately on assertion, including mid-transaction.
- Reset values: valid_out=0, wr_out=0, addr_out=BASE_ADDR, data_out=0, done_out=0, err_out=0, err_cnt_out=0, state=HOLD, hold counter=HOLDOFF, index=0, pass=0.
- All outputs are registered.
- HOLD: decrement the hold counter each cycle. At 0, go to ISSUE on the next edge. HOLDOFF=0 enters ISSUE in the first cycle after reset release. ready_in is ignored in HOLD.
- ISSUE: valid_out=1, and addr_out/wr_out/data_out stay stable until the handshake. The request completes in the cycle where valid_out & ready_in.
  - On completion with DISTANCE>0: go to GAP with the gap counter set to DISTANCE.
  - On completion with DISTANCE=0: stay in ISSUE with the next request presented the following cycle. valid_out stays high; addr_out changes.
- GAP: valid_out=0. Decrement the gap counter; at 0, go to ISSUE.
- Address: addr_out = BASE_ADDR + index*STRIDE, truncated to ADDR_WIDTH; wrap-around is silent.
- Write data: data_out = zero-extended addr_out XOR DATA_SEED. In reads, data_out = 0.
- wr_out = (MODE==1) & (pass==0).
- Index/pass sequencing:
  - index increments on each completion.
  - At index NUM_REQ-1, index returns to 0 and pass toggles (MODE=1) or stays 0 (MODE=0).
  - End of sequence = end of the read pass.
  - At end of sequence: LOOP=1 continues via GAP/ISSUE; LOOP=0 goes to DONE.
- DONE: valid_out=0, done_out=1 until reset; ready_in ignored.
- ready_in without valid_out has no effect.

Optional Feature:
- Macro CACHEGEN_CHECK_EN.
- Defined: on each read completion, compare data_in against the expected value (addr_out XOR DATA_SEED for MODE=1; data_in ignored for MODE=0). A mismatch sets err_out (sticky until reset) and increments err_cnt_out, saturating at 8'hFF.
- Not defined: err_out and err_cnt_out are tied to 0 and data_in is unused.

Test Plan:
- Defaults; ready_in held 1 -> first valid_out in cycle 81 after reset release; addresses 0,4,8,0,4,… all reads; each valid lasts 1 cycle; 6 idle cycles between requests.
- DISTANCE=0, ready_in=1 -> valid_out continuously high; addr_out changes every cycle.
- ready_in stalled 5 cycles during ISSUE -> valid_out, addr_out, wr_out and data_out all held stable; gap count starts only after the completion cycle.
- MODE=1, LOOP=0, NUM_REQ=2, BASE_ADDR=24'h000100, bench echoes written data:
  - 2 writes at 24'h000100/24'h000104 with data 32'h5A5A0100/32'h5A5A0104, then 2 reads;
  - then done_out=1 and valid_out stays 0.
- With CACHEGEN_CHECK_EN, corrupt one read -> err_out=1, err_cnt_out=1; good reads leave the count unchanged.
- Assert rst low while valid_out=1 -> valid_out=0 asynchronously; after release, full HOLDOFF observed again.
